// File: rtl/nrf_spi_master.sv
// SPI master (MSB first, per-transfer CPOL/CPHA, CS held across bursts) with a 2-flop radio IRQ synchroniser.
// Word latency accept->rx_valid = 1+CLK_DIV+2*CLK_DIV*DATA_W; start is only taken while tx_ready (IDLE/GAP).
module nrf_spi_master #(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 2,
    parameter int CLK_DIV = 4,
    // one spare bit so an out-of-range select can actually be presented and flagged via err
    localparam int CS_W   = $clog2(NUM_CS) + 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              hold_cs,
    input  logic              release_req,
    output logic              tx_ready,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              err,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_CS-1:0] CSN,
    input  logic              irq_n,
    output logic              irq_level,
    output logic              irq_fall
);
    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("nrf_spi_master: CLK_DIV must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_TEARDOWN, S_IDLE_WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [NUM_CS-1:0] csn_q, csn_d;
    logic              sck_q, sck_d, mosi_q, mosi_d, cpol_q, cpol_d, cpha_q, cpha_d;
    logic              hold_q, hold_d, rx_valid_q, rx_valid_d, err_q, err_d;
    logic              irq_s1_q, irq_s1_d, irq_s2_q, irq_s2_d, irq_fall_q, irq_fall_d;
    logic              cs_ok, adv;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        csn_d      = csn_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        hold_d     = hold_q;
        rx_valid_d = 1'b0;
        err_d      = 1'b0;
        adv        = 1'b0;
        cs_ok      = (int'(cs_sel) < NUM_CS);
        irq_s1_d   = irq_n;
        irq_s2_d   = irq_s1_q;
        irq_fall_d = irq_s2_q & ~irq_s1_q;

        case (state_q)
            S_IDLE: begin
                sck_d  = cpol_q;
                mosi_d = 1'b0;
                if (start && cs_ok) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    hold_d  = hold_cs;
                    sck_d   = cpol;
                    csn_d   = ~(NUM_CS'(1) << cs_sel);
                    if (cpha) begin
                        tx_sh_d = tx_data;
                    end else begin
                        mosi_d  = tx_data[DATA_W-1];
                        tx_sh_d = {tx_data[DATA_W-2:0], 1'b0};
                    end
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sck_d   = ~cpol_q;
                    adv     = cpha_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // MISO is taken one system clock after the sampling SCK edge, while the slave's data is settled
                if ((cnt_q == '0 && !cpha_q) || (cnt_q == HALF && cpha_q)) begin
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
                end
                if (cnt_q == HALF_LAST) begin
                    sck_d = cpol_q;
                    adv   = ~cpha_q;
                end
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        state_d    = hold_q ? S_GAP : S_TEARDOWN;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        sck_d = ~cpol_q;
                        adv   = cpha_q;
                    end
                end
            end
            S_GAP: begin
                sck_d = cpol_q;
                if (start) begin
                    // first bit goes out with the leading edge for either phase, since there is no SETUP here
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    hold_d  = hold_cs;
                    sck_d   = ~cpol_q;
                    mosi_d  = tx_data[DATA_W-1];
                    tx_sh_d = {tx_data[DATA_W-2:0], 1'b0};
                end else if (release_req) begin
                    state_d = S_TEARDOWN;
                    cnt_d   = '0;
                end
            end
            S_TEARDOWN: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_IDLE_WAIT;
                    cnt_d   = '0;
                    csn_d   = '1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE_WAIT: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    mosi_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            csn_q      <= '1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            hold_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            irq_s1_q   <= 1'b1;
            irq_s2_q   <= 1'b1;
            irq_fall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            csn_q      <= csn_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            hold_q     <= hold_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
            irq_s1_q   <= irq_s1_d;
            irq_s2_q   <= irq_s2_d;
            irq_fall_q <= irq_fall_d;
        end
    end

    assign tx_ready  = (state_q == S_IDLE) || (state_q == S_GAP);
    assign busy      = (state_q != S_IDLE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign err       = err_q;
    assign SCK       = sck_q;
    assign MOSI      = mosi_q;
    assign CSN       = csn_q;
    assign irq_level = irq_s2_q;
    assign irq_fall  = irq_fall_q;
endmodule

// File: tb/tb_nrf_spi_master.sv
// Bench for nrf_spi_master: a cycle timeline model of the transfer rules, checked every cycle, plus literal pins.
module tb_nrf_spi_master;
    localparam int DW = 8, NCS = 2, CD = 4, MAXC = 2000;
    localparam int WORD_CYC = 2 * CD * DW;

    logic       CLOCK_50 = 1'b0, RESET = 1'b0, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic       hold_cs = 1'b0, release_req = 1'b0, irq_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] cs_sel = 2'd0;
    logic       tx_ready, busy, rx_valid, err, SCK, MOSI, MISO, irq_level, irq_fall;
    logic [7:0] rx_data;
    logic [1:0] CSN;

    nrf_spi_master #(.DATA_W(DW), .NUM_CS(NCS), .CLK_DIV(CD)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .hold_cs(hold_cs), .release_req(release_req),
        .tx_ready(tx_ready), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid), .err(err),
        .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .CSN(CSN), .irq_n(irq_n),
        .irq_level(irq_level), .irq_fall(irq_fall));

    assign MISO = MOSI;  // loopback slave

    initial forever #10 CLOCK_50 = ~CLOCK_50;

    // expected timeline, one entry per cycle
    logic       e_sck[MAXC], e_busy[MAXC], e_rdy[MAXC], e_rxv[MAXC], e_err[MAXC], samp[MAXC];
    logic [1:0] e_csn[MAXC];
    logic [7:0] e_rxd[MAXC];

    int cyc = -1, nvec = 0, nbad = 0;
    int rxv_cyc[$], rise_cyc[$], fall_cyc[$];
    logic [7:0] rxv_dat[$];
    logic mosi_rule = 1'b0, sck_p = 1'b0, mosi_p = 1'b0;
    logic [1:0] csn_p = 2'b11;

    task automatic chkv(string nm, logic [7:0] act, logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chki(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(posedge CLOCK_50) begin
        #1;
        cyc++;
        if (cyc < MAXC) begin
            samp[cyc] = irq_n;
            chkv("sck", SCK, e_sck[cyc]);
            chkv("csn", CSN, e_csn[cyc]);
            chkv("busy", busy, e_busy[cyc]);
            chkv("tx_ready", tx_ready, e_rdy[cyc]);
            chkv("rx_valid", rx_valid, e_rxv[cyc]);
            chkv("rx_data", rx_data, e_rxd[cyc]);
            chkv("err", err, e_err[cyc]);
            if (cyc >= 2) begin
                chkv("irq_level", irq_level, samp[cyc-1]);
                chkv("irq_fall", irq_fall, samp[cyc-2] & ~samp[cyc-1]);
            end
            if (mosi_rule && csn_p != 2'b11 && CSN != 2'b11 && MOSI !== mosi_p)
                chkv("mosi_on_sck_fall", {sck_p, SCK}, 8'h02);
            if (rx_valid === 1'b1) begin rxv_cyc.push_back(cyc); rxv_dat.push_back(rx_data); end
            if (SCK === 1'b1 && sck_p === 1'b0) rise_cyc.push_back(cyc);
            if (irq_fall === 1'b1) fall_cyc.push_back(cyc);
            sck_p = SCK; mosi_p = MOSI; csn_p = CSN;
        end
    end

    task automatic fill(int a, int b, logic sck, logic [1:0] csn, logic bsy, logic rdy);
        for (int c = a; c < b && c < MAXC; c++) begin
            e_sck[c] = sck; e_csn[c] = csn; e_busy[c] = bsy; e_rdy[c] = rdy;
            e_rxv[c] = 1'b0; e_err[c] = 1'b0;
        end
    endtask

    task automatic set_rx(int c, logic [7:0] d);
        if (c < MAXC) e_rxv[c] = 1'b1;
        for (int k = c; k < MAXC; k++) e_rxd[k] = d;
    endtask

    task automatic teardown(int t, logic pol, logic [1:0] csn);
        fill(t, t + CD, pol, csn, 1'b1, 1'b0);
        fill(t + CD, t + 2 * CD, pol, 2'b11, 1'b1, 1'b0);
        fill(t + 2 * CD, MAXC, pol, 2'b11, 1'b0, 1'b1);
    endtask

    // SHIFT from cycle a, then GAP or TEARDOWN with the word reported on exit
    task automatic word(int a, logic pol, logic [1:0] csn, logic hold, logic [7:0] d);
        for (int k = 0; k < DW; k++) begin
            fill(a + 2 * CD * k, a + 2 * CD * k + CD, ~pol, csn, 1'b1, 1'b0);
            fill(a + 2 * CD * k + CD, a + 2 * CD * (k + 1), pol, csn, 1'b1, 1'b0);
        end
        if (hold) fill(a + WORD_CYC, MAXC, pol, csn, 1'b1, 1'b1);
        else teardown(a + WORD_CYC, pol, csn);
        set_rx(a + WORD_CYC, d);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic first_word(logic [7:0] d, int cs, logic pol, logic pha, logic hold, output int s);
        logic [1:0] csnl;
        s = cyc;
        csnl = ~(2'b01 << cs);
        start = 1'b1; tx_data = d; cs_sel = 2'(cs); cpol = pol; cpha = pha; hold_cs = hold;
        fill(s + 1, s + 1 + CD, pol, csnl, 1'b1, 1'b0);
        word(s + 1 + CD, pol, csnl, hold, d);
        tick();
        start = 1'b0; hold_cs = 1'b0; cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0;
    endtask

    task automatic gap_word(logic [7:0] d, logic hold, logic rel, logic pol, logic [1:0] csnl, output int s);
        s = cyc;
        start = 1'b1; tx_data = d; hold_cs = hold; release_req = rel;
        cpol = ~pol; cs_sel = 2'd3;  // must be ignored in GAP
        word(s + 1, pol, csnl, hold, d);
        tick();
        start = 1'b0; hold_cs = 1'b0; release_req = 1'b0; cpol = 1'b0; cs_sel = 2'd0;
    endtask

    task automatic clear_logs();
        rxv_cyc.delete(); rxv_dat.delete(); rise_cyc.delete(); fall_cyc.delete();
    endtask

    initial begin
        #(20 * (MAXC - 20));
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s, g;
        fill(0, MAXC, 1'b0, 2'b11, 1'b0, 1'b1);
        for (int c = 0; c < MAXC; c++) e_rxd[c] = 8'h00;

        // reset state
        tick();
        chkv("rst_csn", CSN, 2'b11);
        chkv("rst_sck", SCK, 1'b0);
        chkv("rst_mosi", MOSI, 1'b0);
        chkv("rst_ready", tx_ready, 1'b1);
        chkv("rst_irq_level", irq_level, 1'b1);
        tick(); tick();
        RESET = 1'b1;
        tick(); tick();

        // mode 0, CS0, 0xA5
        clear_logs();
        mosi_rule = 1'b1;
        first_word(8'hA5, 0, 1'b0, 1'b0, 1'b0, s);
        chkv("t1_csn_low", CSN, 2'b10);
        wait_until(s + 73);
        chkv("t1_csn_high", CSN, 2'b11);
        wait_until(s + 80);
        mosi_rule = 1'b0;
        chki("t1_rxv_count", rxv_cyc.size(), 1);
        if (rxv_cyc.size() == 1) begin
            chki("t1_rxv_latency", rxv_cyc[0] - s, 69);
            chkv("t1_rx_data", rxv_dat[0], 8'hA5);
        end
        chki("t1_sck_rises", rise_cyc.size(), 8);
        if (rise_cyc.size() == 8) begin
            chki("t1_first_rise", rise_cyc[0] - s, 5);
            chki("t1_rise_span", rise_cyc[7] - rise_cyc[0], 56);
        end

        // mode 3, 0x3C
        clear_logs();
        mosi_rule = 1'b1;
        first_word(8'h3C, 0, 1'b1, 1'b1, 1'b0, s);
        wait_until(s + 80);
        mosi_rule = 1'b0;
        chkv("t2_sck_idle", SCK, 1'b1);
        chki("t2_rxv_count", rxv_cyc.size(), 1);
        if (rxv_cyc.size() == 1) chkv("t2_rx_data", rxv_dat[0], 8'h3C);

        // burst on CS1: 0x20 held, then 0x0F
        clear_logs();
        first_word(8'h20, 1, 1'b0, 1'b0, 1'b1, s);
        wait_until(s + 72);
        chkv("t3_gap_csn", CSN, 2'b01);
        gap_word(8'h0F, 1'b0, 1'b0, 1'b0, 2'b01, g);
        chkv("t3_second_sck", SCK, 1'b1);
        wait_until(g + 65 + 2 * CD + 2);
        chki("t3_rxv_count", rxv_cyc.size(), 2);
        if (rxv_cyc.size() == 2) begin
            chkv("t3_rx0", rxv_dat[0], 8'h20);
            chkv("t3_rx1", rxv_dat[1], 8'h0F);
            chki("t3_rx1_latency", rxv_cyc[1] - g, 65);
        end

        // GAP with start and release together
        clear_logs();
        first_word(8'h81, 0, 1'b0, 1'b0, 1'b1, s);
        wait_until(s + 70);
        gap_word(8'h96, 1'b0, 1'b1, 1'b0, 2'b10, g);
        wait_until(g + 65 + 2 * CD + 2);
        chki("t4_rxv_count", rxv_cyc.size(), 2);
        if (rxv_cyc.size() == 2) chkv("t4_rx1", rxv_dat[1], 8'h96);

        // out-of-range chip select
        s = cyc;
        start = 1'b1; cs_sel = 2'd2; tx_data = 8'hFF;
        e_err[s + 1] = 1'b1;
        tick();
        start = 1'b0; cs_sel = 2'd0;
        chkv("t5_err", err, 1'b1);
        chkv("t5_csn", CSN, 2'b11);
        chkv("t5_busy", busy, 1'b0);
        tick(); tick();

        // reset during bit 4
        clear_logs();
        first_word(8'h5A, 0, 1'b0, 1'b0, 1'b0, s);
        wait_until(s + 38);
        chkv("t6_sck_before", SCK, 1'b1);
        #1;
        RESET = 1'b0;
        fill(s + 39, MAXC, 1'b0, 2'b11, 1'b0, 1'b1);
        for (int c = s + 39; c < MAXC; c++) e_rxd[c] = 8'h00;
        #1;
        chkv("t6_csn_now", CSN, 2'b11);
        chkv("t6_sck_now", SCK, 1'b0);
        tick(); tick();
        RESET = 1'b1;
        wait_until(s + 80);
        chki("t6_no_rxv", rxv_cyc.size(), 0);

        // IRQ falling edge
        clear_logs();
        s = cyc;
        irq_n = 1'b0;
        wait_until(s + 8);
        chki("t7_fall_count", fall_cyc.size(), 1);
        if (fall_cyc.size() == 1) chki("t7_fall_delay", fall_cyc[0] - s, 2);
        chkv("t7_level", irq_level, 1'b0);
        irq_n = 1'b1;
        wait_until(s + 14);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
